prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Instruction encoder/loader, the write-side counterpart of the instruction decode stage.
- Accepts instruction fields (opcode, rd, rs, imm) over a valid/ready stream.
- Packs each into the 16-bit instruction format and writes it sequentially into the 16-entry instruction memory.
- Holds the CPU in reset-hold while loading; pads unused entries with NOP, then releases the CPU.

Parameters:
- AW, 4, instruction memory address width; depth = 2**AW (16).
- PAD_NOP, 1, 1 = fill remaining entries with NOP after the last word; 0 = go straight to DONE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load session from address 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle this cycle.
- in_opcode  in  4  opcode (values from defines.v).
- in_rd  in  3  destination register.
- in_rs  in  3  source register.
- in_imm  in  9  immediate (used by ADDI only).
- in_last  in  1  marks final bundle of the program.
- mem_we  out  1  instruction memory write enable.
- mem_waddr  out  AW  write address.
- mem_wdata  out  16  encoded instruction.
- cpu_hold  out  1  1 = CPU must not fetch.
- done  out  1  load session complete.
- err_full  out  1  sticky; program overflowed the memory without in_last.
- load_cnt  out  AW+1  number of program words accepted this session.

Behaviour:
- Reset (synchronous, active-high) outputs: in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, done=0, err_full=0, load_cnt=0; state IDLE.
- Reset during LOAD/PAD aborts the session; no partial write completes after the reset edge.
- Encoding, combinational from fields, registered on accept. Format: opcode [3:0], rd [6:4], rs [9:7], imm [15:7].
  - ADDI_op: {in_imm, in_rd, in_opcode}; in_rs ignored.
  - NOP_op: 16'h0000 | NOP_op; all other fields forced to 0.
  - Any other opcode: {6'b0, in_rs, in_rd, in_opcode}.
- State machine with states IDLE, LOAD, PAD, DONE:
  - IDLE: in_ready=0. start -> LOAD; clears addr, load_cnt, err_full and done; cpu_hold=1.
  - LOAD: in_ready=1. Accept = in_valid & in_ready.
    - On accept: mem_we=1 next cycle with mem_waddr=addr and mem_wdata=encoded word (1-cycle registered latency). addr++, load_cnt++.
    - Accept with in_last=1: go to PAD if PAD_NOP and addr != 2**AW-1, else DONE.
    - Accept at addr 2**AW-1 without in_last: err_full=1, go to DONE. Memory is fully written; the word is still written.
    - Accept at addr 2**AW-1 with in_last: go to DONE, no error.
    - in_valid low: no write, state held.
  - PAD: in_ready=0. One NOP write per cycle to addr, addr++. After writing 2**AW-1 -> DONE. load_cnt unchanged.
  - DONE: in_ready=0, mem_we=0, done=1, cpu_hold=0 (registered, first cycle in DONE). start -> LOAD: cpu_hold=1 and done=0 next cycle.
- start is ignored in LOAD and PAD.
- in_valid is ignored outside LOAD.
- mem_we is never asserted in IDLE or DONE.
- Address wraps are impossible: the FSM exits before addr overflows.

Decomposition:
- defines.v holds opcode constants (NOP_op, ADDI_op, others), field bit positions, instruction width 16, and state encodings.
- One sub-module, inst_encoder: combinational fields -> 16-bit word. The loader FSM, address counter and output registers stay in prog_loader.

Test Plan:
- start; 3 bundles ADDI rd=1 imm=5, ADD rd=2 rs=1, in_last on third NOP, PAD_NOP=1 -> writes 0:16'h0291, 1:16'h00A0|ADD_op, 2:NOP; addrs 3..15 NOP; done=1, cpu_hold=0, load_cnt=3.
- Back-pressure: in_valid toggled every other cycle -> only valid cycles write, addresses contiguous, mem_we exactly 1 cycle after each accept.
- 17 bundles, none with in_last -> 16 writes, err_full=1 after the 16th, done=1, 17th bundle never accepted (in_ready=0).
- 16 bundles, in_last on the 16th -> err_full=0, no PAD cycles, done=1.
- rst asserted mid-LOAD after 4 writes -> next cycle all outputs at reset values, cpu_hold=1, state IDLE; a fresh start reloads from address 0.
- start pulsed during LOAD and during PAD -> ignored. start in DONE -> new session, done=0, cpu_hold=1, load_cnt=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants and types for the instruction loader: opcodes, FSM states,
// and the field bundle fed to the encoder.
package prog_loader_pkg;
  localparam int IW = 16;

  localparam logic [3:0] NOP_op  = 4'h0;
  localparam logic [3:0] ADDI_op = 4'h1;
  localparam logic [3:0] ADD_op  = 4'h2;
  localparam logic [3:0] SUB_op  = 4'h3;
  localparam logic [3:0] AND_op  = 4'h4;
  localparam logic [3:0] OR_op   = 4'h5;
  localparam logic [3:0] LD_op   = 4'h6;
  localparam logic [3:0] ST_op   = 4'h7;

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [8:0] imm;
  } fields_t;
endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready field-bundle stream into the loader.
interface prog_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [2:0] in_rd;
  logic [2:0] in_rs;
  logic [8:0] in_imm;
  logic       in_last;

  modport master (output in_valid, in_opcode, in_rd, in_rs, in_imm, in_last,
                  input  in_ready);
  modport slave  (input  in_valid, in_opcode, in_rd, in_rs, in_imm, in_last,
                  output in_ready);
endinterface

// File: rtl/prog_loader_inst_encoder.sv
// Packs instruction fields into the 16-bit format: opcode[3:0], rd[6:4],
// rs[9:7], imm[15:7] (ADDI only; rs and imm share bits).
module inst_encoder
  import prog_loader_pkg::*;
(
  input  fields_t         fld,
  output logic [IW-1:0]   word
);
  always_comb begin
    word = '0;
    case (fld.opcode)
      NOP_op:  word = {12'h000, NOP_op};
      ADDI_op: word = {fld.imm, fld.rd, fld.opcode};
      default: word = {6'b0, fld.rs, fld.rd, fld.opcode};
    endcase
  end
endmodule

// File: rtl/prog_loader.sv
// Streams encoded instructions into instruction memory, optionally NOP-pads
// the remainder, and holds the CPU until the image is complete.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int AW      = 4,
  parameter bit PAD_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  prog_loader_if.slave    src,
  output logic            mem_we,
  output logic [AW-1:0]   mem_waddr,
  output logic [IW-1:0]   mem_wdata,
  output logic            cpu_hold,
  output logic            done,
  output logic            err_full,
  output logic [AW:0]     load_cnt
);
  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q;
  fields_t         fld;
  logic [IW-1:0]   enc_word;
  logic            accept, last_addr;
  logic            wr_en, clr, inc_cnt, set_err;
  logic [IW-1:0]   wr_data;

  assign fld          = {src.in_opcode, src.in_rd, src.in_rs, src.in_imm};
  assign src.in_ready = (state_q == LOAD);
  assign accept       = src.in_valid & src.in_ready;
  assign last_addr    = (addr_q == {AW{1'b1}});

  inst_encoder u_enc (.fld(fld), .word(enc_word));

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_data = '0;
    clr     = 1'b0;
    inc_cnt = 1'b0;
    set_err = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        clr     = 1'b1;
      end
      LOAD: if (accept) begin
        wr_en   = 1'b1;
        wr_data = enc_word;
        inc_cnt = 1'b1;
        // Filling the final slot ends the session; without in_last it overflowed.
        if (last_addr) begin
          state_d = DONE;
          set_err = ~src.in_last;
        end else if (src.in_last) begin
          state_d = PAD_NOP ? PAD : DONE;
        end
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_data = {12'h000, NOP_op};
        if (last_addr) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err_full  <= 1'b0;
      load_cnt  <= '0;
    end else begin
      state_q <= state_d;
      mem_we  <= wr_en;
      if (wr_en) begin
        mem_waddr <= addr_q;
        mem_wdata <= wr_data;
      end
      if (clr) begin
        addr_q   <= '0;
        load_cnt <= '0;
        err_full <= 1'b0;
      end else begin
        if (wr_en)   addr_q   <= addr_q + 1'b1;
        if (inc_cnt) load_cnt <= load_cnt + 1'b1;
        if (set_err) err_full <= 1'b1;
      end
      // Status follows the next state so it lands on the first DONE cycle.
      done     <= (state_d == DONE);
      cpu_hold <= (state_d != DONE);
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard (address, data, cycle).
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        mem_we, cpu_hold, done, err_full;
  logic [3:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic [4:0]  load_cnt;

  prog_loader_if bus ();

  prog_loader #(.AW(4), .PAD_NOP(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .src(bus),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err_full(err_full), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   m_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL wr_unexpected addr=%0d data=%h cyc=%0d required no write", mem_waddr, mem_wdata, cyc);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        total++;
        assert (mem_waddr === e.addr && mem_wdata === e.data && cyc == e.cyc) else begin
          bad++;
          $error("FAIL wr addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                 mem_waddr, mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_exp(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [8:0] imm);
    if (op == NOP_op)  return 16'h0000;
    if (op == ADDI_op) return (16'(imm) << 7) | (16'(rd) << 4) | 16'(op);
    return (16'(rs) << 7) | (16'(rd) << 4) | 16'(op);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic new_session();
    pulse_start();
    m_addr = 0;
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [8:0] imm, input logic last, input logic [15:0] exp_w,
                      input bit exp_acc);
    bus.in_opcode = op; bus.in_rd = rd; bus.in_rs = rs; bus.in_imm = imm;
    bus.in_last = last; bus.in_valid = 1'b1;
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_acc});
    if (exp_acc) begin
      q.push_back('{4'(m_addr), exp_w, cyc + 1});
      m_addr++;
      if (last && m_addr < 16)
        for (int j = m_addr; j < 16; j++) q.push_back('{4'(j), 16'h0000, cyc + 2 + (j - m_addr)});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  {31'b0, bus.in_ready}, 32'd0);
    chk({tag, "_we"},     {31'b0, mem_we},       32'd0);
    chk({tag, "_waddr"},  {28'b0, mem_waddr},    32'd0);
    chk({tag, "_wdata"},  {16'b0, mem_wdata},    32'd0);
    chk({tag, "_hold"},   {31'b0, cpu_hold},     32'd1);
    chk({tag, "_done"},   {31'b0, done},         32'd0);
    chk({tag, "_err"},    {31'b0, err_full},     32'd0);
    chk({tag, "_cnt"},    {27'b0, load_cnt},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [2:0] rd, rs;
    logic [8:0] imm;
    logic [3:0] op;
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs = '0; bus.in_imm = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // Session 1: small program, start ignored in LOAD and PAD
    new_session();
    send(ADDI_op, 3'd1, 3'd0, 9'd5, 1'b0, 16'h0291, 1'b1);
    send(ADD_op,  3'd2, 3'd1, 9'd0, 1'b0, 16'h00A2, 1'b1);
    pulse_start();
    chk("load_hold", {31'b0, cpu_hold}, 32'd1);
    chk("load_done", {31'b0, done}, 32'd0);
    send(NOP_op, 3'd7, 3'd7, 9'h1FF, 1'b1, 16'h0000, 1'b1);
    pulse_start();
    wait_done();
    chk("s1_q_empty", q.size(), 32'd0);
    chk("s1_done", {31'b0, done}, 32'd1);
    chk("s1_hold", {31'b0, cpu_hold}, 32'd0);
    chk("s1_cnt",  {27'b0, load_cnt}, 32'd3);
    chk("s1_err",  {31'b0, err_full}, 32'd0);

    // Session 2 from DONE: back-pressure, valid every other cycle
    new_session();
    chk("s2_done", {31'b0, done}, 32'd0);
    chk("s2_hold", {31'b0, cpu_hold}, 32'd1);
    chk("s2_cnt",  {27'b0, load_cnt}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      op = 4'(i + 1); rd = 3'($urandom_range(7)); rs = 3'($urandom_range(7));
      imm = 9'($urandom_range(511));
      send(op, rd, rs, imm, i == 5, enc_exp(op, rd, rs, imm), 1'b1);
      if (i < 5) @(negedge clk);
    end
    wait_done();
    chk("s2_q_empty", q.size(), 32'd0);
    chk("s2_cnt", {27'b0, load_cnt}, 32'd6);

    // Session 3: overflow, 17 bundles without in_last
    new_session();
    for (int i = 0; i < 17; i++) begin
      rd = 3'(i); rs = 3'(7 - (i % 8));
      send(SUB_op, rd, rs, 9'd0, 1'b0, enc_exp(SUB_op, rd, rs, 9'd0), i < 16);
      if (i == 15) begin
        chk("s3_err",  {31'b0, err_full}, 32'd1);
        chk("s3_done", {31'b0, done}, 32'd1);
      end
    end
    @(negedge clk);
    chk("s3_q_empty", q.size(), 32'd0);
    chk("s3_cnt", {27'b0, load_cnt}, 32'd16);
    chk("s3_hold", {31'b0, cpu_hold}, 32'd0);

    // Session 4: exactly full with in_last on the 16th, no padding
    new_session();
    chk("s4_err_clr", {31'b0, err_full}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      imm = 9'(i * 31); rd = 3'(i + 3);
      send(ADDI_op, rd, 3'd0, imm, i == 15, enc_exp(ADDI_op, rd, 3'd0, imm), 1'b1);
    end
    chk("s4_done", {31'b0, done}, 32'd1);
    chk("s4_err",  {31'b0, err_full}, 32'd0);
    repeat (2) @(negedge clk);
    chk("s4_q_empty", q.size(), 32'd0);
    chk("s4_cnt", {27'b0, load_cnt}, 32'd16);

    // Session 5: reset mid-LOAD with a bundle offered on the reset edge
    new_session();
    for (int i = 0; i < 4; i++) send(OR_op, 3'(i), 3'(i + 1), 9'd0, 1'b0,
                                     enc_exp(OR_op, 3'(i), 3'(i + 1), 9'd0), 1'b1);
    bus.in_opcode = LD_op; bus.in_rd = 3'd5; bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'b0, bus.in_ready}, 32'd0);
    new_session();
    send(ST_op, 3'd4, 3'd6, 9'd0, 1'b0, enc_exp(ST_op, 3'd4, 3'd6, 9'd0), 1'b1);
    send(AND_op, 3'd1, 3'd2, 9'd0, 1'b1, enc_exp(AND_op, 3'd1, 3'd2, 9'd0), 1'b1);
    wait_done();
    chk("s5_q_empty", q.size(), 32'd0);
    chk("s5_cnt", {27'b0, load_cnt}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
